inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Instruction-side responder for the fetch stage. Accepts PC requests over a valid/ready handshake, reads a word-addressed instruction store, and returns {pc, instruction, error} in request order after a fixed latency.
- Buffers responses in a small FIFO so decode back-pressure never loses a fetch.
- Supports a flush for redirects: branches, jumps, jr, exception vectors 0x80000004/0x80000008.

Parameters:
- ADDR_W, 8, word-index width; store holds 2^ADDR_W 32-bit words.
- LATENCY, 2, request-to-response latency in cycles; legal range 1..4.
- FIFO_DEPTH, 4, response buffer entries (power of 2, >= LATENCY).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  request can be accepted this cycle.
- req_pc  input  32  fetch address.
- flush  input  1  discard all in-flight and buffered fetches.
- rsp_valid  output  1  response at FIFO head.
- rsp_ready  input  1  consumer takes response.
- rsp_pc  output  32  PC of returned instruction.
- rsp_inst  output  32  instruction word (0x00000000 on error).
- rsp_err  output  1  misaligned or out-of-range fetch.
- rsp_predec  output  3  predecode class (see Optional Feature).
- prog_we  input  1  store write enable.
- prog_addr  input  ADDR_W  store write word index.
- prog_data  input  32  store write data.

Behaviour:
- Accept occurs when req_valid && req_ready at a rising edge.
- req_ready = !reset && !flush && (inflight + fifo_count) < FIFO_DEPTH.
  - This is credit-based, so the FIFO never overflows.
- Address decode:
  - req_pc[31] is ignored, so the kernel range 0x8xxxxxxx mirrors user space.
  - Word index = req_pc[ADDR_W+1:2].
  - rsp_err=1 and rsp_inst=0 if req_pc[1:0]!=0 or req_pc[30:ADDR_W+2]!=0.
- Store read is sampled in the accept cycle.
  - A prog_we to the same index in that cycle returns the old word; the write takes effect the next cycle.
- Latency:
  - With FIFO empty, a request accepted in cycle T produces rsp_valid=1 in cycle T+LATENCY.
  - Back-to-back accepts yield back-to-back responses.
- Ordering: responses leave strictly in acceptance order.
- FIFO:
  - Pop when rsp_valid && rsp_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full with a pop.
  - Head outputs hold stable while rsp_valid && !rsp_ready.
- Flush:
  - All in-flight stage valids and the FIFO clear at the edge ending the flush cycle.
  - No request is accepted during flush.
  - rsp_valid=0 from the next cycle; a pop in the flush cycle is still honoured.
  - First request after flush (accepted T+1) responds at T+1+LATENCY.
- Reset:
  - rsp_valid=0, rsp_pc=0, rsp_inst=0, rsp_err=0, rsp_predec=0, FIFO and stages empty.
  - req_ready=0 while reset is high and 1 the cycle after.
  - Reset mid-operation drops everything, same as flush.
  - Store contents are not cleared by reset.
- Pointer wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are determined by MSB compare.

Optional Feature:
- Macro: FETCH_PREDECODE_EN.
- Defined: rsp_predec is computed from the stored instruction when it enters the FIFO.
  - 3'd1: opcode 1, 4, 5, 6 or 7 (branch).
  - 3'd2: opcode 2 or 3 (j/jal).
  - 3'd3: opcode 0 with funct 8 or 9 (jr/jalr).
  - 3'd0: otherwise, or when rsp_err=1.
- Undefined: rsp_predec is tied to 3'd0 and there is no predecode logic.

Test Plan:
- Reset, store[0]=0x20080005, store[1]=0x08000010, LATENCY=2; request 0x80000000 then 0x80000004 in cycles T, T+1 with rsp_ready=1 -> rsp_valid at T+2 and T+3 with inst 0x20080005 then 0x08000010; rsp_pc echoes the request; rsp_err=0.
- rsp_ready=0, issue 6 requests back-to-back -> exactly 4 accepted (req_ready drops after the 4th credit); raise rsp_ready -> 4 responses in order; req_ready returns to 1.
- Request 0x80000002 and 0x80000400 (ADDR_W=8) -> rsp_err=1, rsp_inst=0x00000000, rsp_predec=0.
- Two requests in flight, assert flush one cycle, then request 0x80000008 -> the flushed responses never appear; 0x80000008 response arrives LATENCY cycles after its accept.
- prog_we to index 3 with 0xAAAA5555 in the same cycle as a fetch of 0x0000000C (old word 0x11111111) -> response returns 0x11111111; a refetch returns 0xAAAA5555.
- With FETCH_PREDECODE_EN: fetch 0x1109FFFF (beq), 0x0C000020 (jal), 0x03E00008 (jr) -> rsp_predec 1, 2, 3; without the macro -> all 0.

Source files
------------

// File: rtl/inst_fetch_responder_if.sv
// rtl/inst_fetch_responder_if.sv - fetch request/response and store-programming bundle
// Purpose: groups the fetch request channel, flush, response channel and the
//          instruction-store write port of inst_fetch_responder.
// Ports (signals):
//   req_valid/req_ready/req_pc                          fetch request handshake
//   flush                                               drop all outstanding fetches
//   rsp_valid/rsp_ready/rsp_pc/rsp_inst/rsp_err/rsp_predec  response handshake
//   prog_we/prog_addr/prog_data                         instruction store write
// Modports: master = fetch stage / programmer, slave = responder.
interface inst_fetch_responder_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_pc;
   logic              flush;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_pc;
   logic [31:0]       rsp_inst;
   logic              rsp_err;
   logic [2:0]        rsp_predec;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [31:0]       prog_data;

   modport master (
      output req_valid, req_pc, flush, rsp_ready, prog_we, prog_addr, prog_data,
      input  req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_err, rsp_predec
   );

   modport slave (
      input  req_valid, req_pc, flush, rsp_ready, prog_we, prog_addr, prog_data,
      output req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_err, rsp_predec
   );
endinterface

// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - instruction fetch responder with in-order response FIFO
// Purpose: accepts PC requests, reads a word-addressed instruction store and
//          returns {pc, instruction, error} in order after LATENCY cycles,
//          buffered in a credit-controlled FIFO so back-pressure never drops a fetch.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (store contents are kept)
//   bus    inst_fetch_responder_if.slave (request, flush, response, store write)
// Optional feature: FETCH_PREDECODE_EN adds a 3-bit predecode class on rsp_predec;
//          when undefined rsp_predec is tied to zero.
module inst_fetch_responder #(
   parameter int ADDR_W     = 8,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   inst_fetch_responder_if.slave  bus
);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = PW + 1;
   localparam int CW    = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } ent_t;

   logic [31:0] store [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (bus.prog_we) store[bus.prog_addr] <= bus.prog_data;
   end

   // Bit 31 only selects the kernel mirror and plays no part in decode.
   logic unused_pc_msb;
   assign unused_pc_msb = bus.req_pc[31];

   ent_t in_ent;
   logic accept;

   // The store is read combinationally in the accept cycle, so a same-cycle
   // write to the same index is seen only by later fetches.
   always_comb begin
      in_ent.pc   = bus.req_pc;
      in_ent.err  = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc[30:ADDR_W+2] != '0);
      in_ent.inst = in_ent.err ? 32'h0 : store[bus.req_pc[ADDR_W+1:2]];
   end

   assign accept = bus.req_valid && bus.req_ready;

   logic          push;
   ent_t          push_ent;
   logic [CW-1:0] inflight;

   // LATENCY-1 register stages feed the FIFO; the FIFO write itself is the
   // final cycle of latency.
   if (LATENCY == 1) begin : g_direct
      assign push     = accept;
      assign push_ent = in_ent;
      assign inflight = '0;
   end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] sv;
      ent_t          sd [NS];

      always_ff @(posedge clk) begin
         if (reset || bus.flush) begin
            sv <= '0;
         end else begin
            sv[0] <= accept;
            for (int i = 1; i < NS; i++) sv[i] <= sv[i-1];
         end
      end

      always_ff @(posedge clk) begin
         sd[0] <= in_ent;
         for (int i = 1; i < NS; i++) sd[i] <= sd[i-1];
      end

      assign push     = sv[NS-1];
      assign push_ent = sd[NS-1];

      always_comb begin
         inflight = '0;
         for (int i = 0; i < NS; i++) inflight = inflight + CW'(sv[i]);
      end
   end

   ent_t             fifo [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] fifo_count;
   logic             fifo_full, pop, do_push;
   logic [CW-1:0]    credit_used;
   ent_t             head;

   assign fifo_count  = wr_ptr - rd_ptr;
   // Full when indices match but the wrap bits differ.
   assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign bus.rsp_valid = (wr_ptr != rd_ptr);
   assign pop         = bus.rsp_valid && bus.rsp_ready;
   assign do_push     = push && (!fifo_full || pop);
   // Every accepted fetch holds a credit until it is popped, so pushes can
   // never find the FIFO full without a matching pop.
   assign credit_used = CW'(fifo_count) + inflight;
   assign bus.req_ready = !reset && !bus.flush && (credit_used < CW'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) fifo[wr_ptr[PW-1:0]] <= push_ent;
   end

   assign head         = fifo[rd_ptr[PW-1:0]];
   // Outputs read zero whenever the FIFO is empty, including after reset.
   assign bus.rsp_pc   = bus.rsp_valid ? head.pc   : 32'h0;
   assign bus.rsp_inst = bus.rsp_valid ? head.inst : 32'h0;
   assign bus.rsp_err  = bus.rsp_valid && head.err;

`ifdef FETCH_PREDECODE_EN
   logic [2:0] fifo_pd [FIFO_DEPTH];

   function automatic logic [2:0] predecode(input logic [31:0] w, input logic e);
      logic [2:0] c;
      c = 3'd0;
      if (!e) begin
         case (w[31:26])
            6'd1, 6'd4, 6'd5, 6'd6, 6'd7: c = 3'd1;
            6'd2, 6'd3:                   c = 3'd2;
            6'd0: if (w[5:0] == 6'd8 || w[5:0] == 6'd9) c = 3'd3;
            default:                      c = 3'd0;
         endcase
      end
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) fifo_pd[wr_ptr[PW-1:0]] <= predecode(push_ent.inst, push_ent.err);
   end

   assign bus.rsp_predec = bus.rsp_valid ? fifo_pd[rd_ptr[PW-1:0]] : 3'd0;
`else
   assign bus.rsp_predec = 3'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb/tb_inst_fetch_responder.sv - directed bench with response scoreboard for inst_fetch_responder
module tb_inst_fetch_responder;
   localparam int ADDR_W = 8;
`ifdef FETCH_PREDECODE_EN
   localparam bit PD_EN = 1'b1;
`else
   localparam bit PD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_responder_if #(.ADDR_W(ADDR_W)) bus ();

   inst_fetch_responder #(.ADDR_W(ADDR_W), .LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
      logic [2:0]  pd;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model [2**ADDR_W];
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ref_pd(input logic [31:0] w, input logic e);
      logic [2:0] c;
      c = 3'd0;
      if (w[31:26] inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7}) c = 3'd1;
      else if (w[31:26] inside {6'd2, 6'd3}) c = 3'd2;
      else if (w[31:26] == 6'd0 && (w[5:0] == 6'd8 || w[5:0] == 6'd9)) c = 3'd3;
      return (PD_EN && !e) ? c : 3'd0;
   endfunction

   task automatic pop_check();
      exp_t e;
      if (q.size() == 0) begin
         check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("sb_rsp_pc", bus.rsp_pc, e.pc);
         check("sb_rsp_inst", bus.rsp_inst, e.inst);
         check("sb_rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
         check("sb_rsp_predec", {29'd0, bus.rsp_predec}, {29'd0, e.pd});
      end
   endtask

   // Scoreboard: expectations pushed on accept, compared on pop.
   always @(negedge clk) begin
      exp_t e;
      if (reset || bus.flush) begin
         if (!reset && bus.rsp_valid && bus.rsp_ready) pop_check();
         q.delete();
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) pop_check();
         if (bus.req_valid && bus.req_ready) begin
            e.pc   = bus.req_pc;
            e.err  = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc[30:ADDR_W+2] != '0);
            e.inst = e.err ? 32'h0 : model[bus.req_pc[ADDR_W+1:2]];
            e.pd   = ref_pd(e.inst, e.err);
            q.push_back(e);
         end
      end
      if (bus.prog_we) model[bus.prog_addr] = bus.prog_data;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] init_words [8] = '{32'h20080005, 32'h08000010, 32'h22222222, 32'h11111111,
                                   32'h1109FFFF, 32'h0C000020, 32'h03E00008, 32'h77777777};
   int acc;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_pc    = 32'h0;
      bus.flush     = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = 32'h0;

      // Reset state, with the store programmed while reset is held.
      cyc();
      cyc();
      @(negedge clk);
      check("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset_rsp_pc", bus.rsp_pc, 32'h0);
      check("reset_rsp_inst", bus.rsp_inst, 32'h0);
      check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("reset_rsp_predec", {29'd0, bus.rsp_predec}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         bus.prog_we   = 1'b1;
         bus.prog_addr = ADDR_W'(i);
         bus.prog_data = init_words[i];
      end
      cyc();
      bus.prog_we = 1'b0;
      reset       = 1'b0;
      @(negedge clk);
      check("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Basic fetch through the kernel mirror, latency 2.
      cyc();
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h80000000;
      cyc();
      bus.req_pc    = 32'h80000004;
      @(negedge clk);
      check("lat_t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      cyc();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("lat_t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("lat_t2_rsp_inst", bus.rsp_inst, 32'h20080005);
      check("lat_t2_rsp_pc", bus.rsp_pc, 32'h80000000);
      cyc();
      @(negedge clk);
      check("lat_t3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("lat_t3_rsp_inst", bus.rsp_inst, 32'h08000010);
      check("lat_t3_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("lat_t3_predec", {29'd0, bus.rsp_predec}, PD_EN ? 32'd2 : 32'd0);
      cyc();

      // Credit limit under back-pressure.
      bus.rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         bus.req_valid = 1'b1;
         bus.req_pc    = 32'(i * 4);
         @(negedge clk);
         if (bus.req_ready) acc++;
         cyc();
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("credit_accepts", 32'(acc), 32'd4);
      check("credit_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
      check("stall_head_pc_a", bus.rsp_pc, 32'h0);
      cyc();
      @(negedge clk);
      check("stall_head_pc_b", bus.rsp_pc, 32'h0);
      check("stall_head_inst", bus.rsp_inst, 32'h20080005);
      bus.rsp_ready = 1'b1;
      repeat (8) cyc();
      @(negedge clk);
      check("credit_req_ready_back", {31'd0, bus.req_ready}, 32'd1);
      check("credit_drained", {31'd0, bus.rsp_valid}, 32'd0);
      check("credit_sb_empty", 32'(q.size()), 32'd0);

      // Misaligned and out-of-range fetches.
      cyc();
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h80000002;
      cyc();
      bus.req_pc    = 32'h80000400;
      cyc();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("err_misaligned", {31'd0, bus.rsp_err}, 32'd1);
      check("err_misaligned_inst", bus.rsp_inst, 32'h0);
      cyc();
      @(negedge clk);
      check("err_range", {31'd0, bus.rsp_err}, 32'd1);
      check("err_range_pc", bus.rsp_pc, 32'h80000400);
      repeat (3) cyc();

      // Flush with two fetches outstanding.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h00000000;
      cyc();
      bus.req_pc    = 32'h00000004;
      cyc();
      bus.req_valid = 1'b0;
      bus.flush     = 1'b1;
      @(negedge clk);
      check("flush_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("flush_cycle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      cyc();
      bus.flush     = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h80000008;
      @(negedge clk);
      check("after_flush_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      cyc();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("after_flush_t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      cyc();
      @(negedge clk);
      check("after_flush_t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("after_flush_rsp_pc", bus.rsp_pc, 32'h80000008);
      check("after_flush_rsp_inst", bus.rsp_inst, 32'h22222222);
      bus.rsp_ready = 1'b1;
      repeat (3) cyc();
      check("flush_sb_empty", 32'(q.size()), 32'd0);

      // Store write racing a fetch of the same word.
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0000000C;
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'd3;
      bus.prog_data = 32'hAAAA5555;
      cyc();
      bus.req_valid = 1'b0;
      bus.prog_we   = 1'b0;
      cyc();
      @(negedge clk);
      check("raw_old_word", bus.rsp_inst, 32'h11111111);
      cyc();
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      @(negedge clk);
      check("raw_new_word", bus.rsp_inst, 32'hAAAA5555);
      repeat (2) cyc();

      // Predecode classes.
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h00000010;
      cyc();
      bus.req_pc    = 32'h00000014;
      cyc();
      bus.req_pc    = 32'h00000018;
      @(negedge clk);
      check("predec_branch", {29'd0, bus.rsp_predec}, PD_EN ? 32'd1 : 32'd0);
      cyc();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("predec_jal", {29'd0, bus.rsp_predec}, PD_EN ? 32'd2 : 32'd0);
      cyc();
      @(negedge clk);
      check("predec_jr", {29'd0, bus.rsp_predec}, PD_EN ? 32'd3 : 32'd0);
      repeat (3) cyc();

      // Reset in the middle of operation.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h00000000;
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      @(negedge clk);
      check("midreset_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      check("midreset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("midreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("midreset_req_ready_back", {31'd0, bus.req_ready}, 32'd1);
      check("midreset_rsp_inst", bus.rsp_inst, 32'h0);
      cyc();
      check("final_sb_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
